// File: rtl/mm_pkg.sv
// Shared types and defaults for the 3x3 outer-product matrix driver.
package mm_pkg;

    localparam int MM_DIM = 3;
    localparam int MM_DW  = 8;
    localparam int MM_AW  = 4;

    // Q4.4 fixed-point 1.0
    localparam logic [7:0] Q44_ONE = 8'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_A  = 2'd1,
        SEND_B  = 2'd2,
        COLLECT = 2'd3
    } state_e;

endpackage

// File: rtl/mm_elem_store.sv
// DIM*DIM x DW register array: one write port, two combinational read ports.
// Addresses >= DIM*DIM are ignored on write and read back as 0. Contents are not reset.
module mm_elem_store #(
    parameter int DIM = 3,
    parameter int DW  = 8,
    parameter int AW  = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    output logic [DW-1:0] o_rdata0,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata1
);

    localparam int N = DIM * DIM;

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < N; i++) begin
            if (i_we && (i_waddr == AW'(i))) begin
                mem_d[i] = i_wdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Decoded reads so out-of-range addresses fall through to zero.
    always_comb begin
        o_rdata0 = '0;
        o_rdata1 = '0;
        for (int i = 0; i < N; i++) begin
            if (i_raddr0 == AW'(i)) o_rdata0 = mem_q[i];
            if (i_raddr1 == AW'(i)) o_rdata1 = mem_q[i];
        end
    end

endmodule

// File: rtl/mat_stream_driver.sv
// Streams A columns / B rows into the outer-product multiplier and collects its results.
// Optional macro MM_DRV_LAST_CHECK_EN enables i_res_last protocol checking on o_err.
module mat_stream_driver
    import mm_pkg::*;
#(
    parameter int DIM = MM_DIM,
    parameter int DW  = MM_DW,
    parameter int AW  = MM_AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_load_we,
    input  logic          i_load_sel,
    input  logic [AW-1:0] i_load_addr,
    input  logic [DW-1:0] i_load_data,
    output logic [DW-1:0] o_a_num,
    output logic          o_a_num_valid,
    input  logic          i_a_read,
    output logic [DW-1:0] o_b_num,
    output logic          o_b_num_valid,
    input  logic          i_b_read,
    output logic          o_res_ready,
    input  logic [DW-1:0] i_res_data,
    input  logic          i_res_valid,
    input  logic          i_res_last,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_dbg_state
);

    localparam int N  = DIM * DIM;
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] J_LAST = IW'(DIM - 1);
    localparam logic [AW-1:0] R_LAST = AW'(N - 1);

    // Handshake: a word moves on a rising edge where valid && read/ready are both high;
    // the offered word is held stable until that edge.
    state_e        state_q, state_d;
    logic [IW-1:0] j_q, j_d, k_q, k_d;
    logic [AW-1:0] r_q, r_d;
    logic          a_vld_q, a_vld_d, b_vld_q, b_vld_d, rdy_q, rdy_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic a_xfer, b_xfer, res_acc, res_final, start_acc, load_ok;

    assign a_xfer    = a_vld_q && i_a_read;
    assign b_xfer    = b_vld_q && i_b_read;
    assign res_acc   = rdy_q && i_res_valid;
    assign res_final = res_acc && (r_q == R_LAST);
    assign start_acc = (state_q == IDLE) && i_start;
    assign load_ok   = (state_q == IDLE) && i_load_we;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        r_d     = r_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SEND_A;
                    j_d     = '0;
                    k_d     = '0;
                    r_d     = '0;
                    done_d  = 1'b0;
                end
            end
            SEND_A: begin
                if (a_xfer) begin
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        state_d = SEND_B;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            SEND_B: begin
                if (b_xfer) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (k_q == J_LAST) begin
                            state_d = COLLECT;
                            r_d     = '0;
                        end else begin
                            k_d     = k_q + 1'b1;
                            state_d = SEND_A;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (res_acc) begin
                    r_d = r_q + 1'b1;
                    if (r_q == R_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        a_vld_d = (state_d == SEND_A);
        b_vld_d = (state_d == SEND_B);
        rdy_d   = (state_d == COLLECT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            r_q     <= r_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef MM_DRV_LAST_CHECK_EN
    logic       err_q, err_d;
    logic [1:0] pend_q, pend_d;

    // pend counts down the two-cycle grace window for a late i_res_last after the final word.
    always_comb begin
        err_d  = err_q;
        pend_d = pend_q;
        if (pend_q != 2'd0) begin
            if (i_res_last) begin
                pend_d = 2'd0;
            end else if (pend_q == 2'd1) begin
                err_d  = 1'b1;
                pend_d = 2'd0;
            end else begin
                pend_d = pend_q - 2'd1;
            end
        end
        if (res_acc) begin
            if (i_res_last && !res_final) err_d  = 1'b1;
            if (res_final && !i_res_last) pend_d = 2'd2;
        end
        if (start_acc) begin
            err_d  = 1'b0;
            pend_d = 2'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q  <= 1'b0;
            pend_q <= 2'd0;
        end else begin
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_res_last;
    logic unused_start_acc;
    assign unused_res_last  = i_res_last;
    assign unused_start_acc = start_acc;
    assign o_err = 1'b0;
`endif

    logic [AW-1:0] a_raddr, b_raddr;
    logic [DW-1:0] unused_a_rd1, unused_b_rd1, unused_res_rd1;

    assign a_raddr = AW'(j_q) * AW'(DIM) + AW'(k_q);
    assign b_raddr = AW'(k_q) * AW'(DIM) + AW'(j_q);

    mm_elem_store #(.DIM(DIM), .DW(DW), .AW(AW)) u_a_store (
        .i_clk    (i_clk),
        .i_we     (load_ok && !i_load_sel),
        .i_waddr  (i_load_addr),
        .i_wdata  (i_load_data),
        .i_raddr0 (a_raddr),
        .o_rdata0 (o_a_num),
        .i_raddr1 ('0),
        .o_rdata1 (unused_a_rd1)
    );

    mm_elem_store #(.DIM(DIM), .DW(DW), .AW(AW)) u_b_store (
        .i_clk    (i_clk),
        .i_we     (load_ok && i_load_sel),
        .i_waddr  (i_load_addr),
        .i_wdata  (i_load_data),
        .i_raddr0 (b_raddr),
        .o_rdata0 (o_b_num),
        .i_raddr1 ('0),
        .o_rdata1 (unused_b_rd1)
    );

    mm_elem_store #(.DIM(DIM), .DW(DW), .AW(AW)) u_res_store (
        .i_clk    (i_clk),
        .i_we     (res_acc),
        .i_waddr  (r_q),
        .i_wdata  (i_res_data),
        .i_raddr0 (i_rd_addr),
        .o_rdata0 (o_rd_data),
        .i_raddr1 ('0),
        .o_rdata1 (unused_res_rd1)
    );

    assign o_a_num_valid = a_vld_q;
    assign o_b_num_valid = b_vld_q;
    assign o_res_ready   = rdy_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mat_stream_driver.sv
// Directed bench for mat_stream_driver: operand order, backpressure, collect, ignored inputs,
// mid-run reset and the optional MM_DRV_LAST_CHECK_EN error flag.
module tb_mat_stream_driver;
    import mm_pkg::*;

`ifdef MM_DRV_LAST_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_load_we = 1'b0;
    logic       i_load_sel = 1'b0;
    logic [3:0] i_load_addr = '0;
    logic [7:0] i_load_data = '0;
    logic [7:0] o_a_num;
    logic       o_a_num_valid;
    logic       i_a_read = 1'b0;
    logic [7:0] o_b_num;
    logic       o_b_num_valid;
    logic       i_b_read = 1'b0;
    logic       o_res_ready;
    logic [7:0] i_res_data = '0;
    logic       i_res_valid = 1'b0;
    logic       i_res_last = 1'b0;
    logic [3:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] a_m [9];
    logic [7:0] b_m [9];
    logic [7:0] exp_q [$];

    mat_stream_driver dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_load_we     (i_load_we),
        .i_load_sel    (i_load_sel),
        .i_load_addr   (i_load_addr),
        .i_load_data   (i_load_data),
        .o_a_num       (o_a_num),
        .o_a_num_valid (o_a_num_valid),
        .i_a_read      (i_a_read),
        .o_b_num       (o_b_num),
        .o_b_num_valid (o_b_num_valid),
        .i_b_read      (i_b_read),
        .o_res_ready   (o_res_ready),
        .i_res_data    (i_res_data),
        .i_res_valid   (i_res_valid),
        .i_res_last    (i_res_last),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_dbg_state   (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) exp_q.push_back(a_m[j*3+k]);
            for (int j = 0; j < 3; j++) exp_q.push_back(b_m[k*3+j]);
        end
    endtask

    task automatic load_elem(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        i_load_we = 1'b1; i_load_sel = sel; i_load_addr = addr; i_load_data = data;
        if (addr < 4'd9) begin
            if (sel) b_m[addr] = data;
            else     a_m[addr] = data;
        end
        @(negedge i_clk);
        i_load_we = 1'b0;
    endtask

    task automatic do_start(input logic wl, input logic sel, input logic [3:0] addr, input logic [7:0] data);
        i_start = 1'b1; i_load_we = wl; i_load_sel = sel; i_load_addr = addr; i_load_data = data;
        if (wl && addr < 4'd9) begin
            if (sel) b_m[addr] = data;
            else     a_m[addr] = data;
        end
        build_exp();
        @(negedge i_clk);
        i_start = 1'b0; i_load_we = 1'b0;
        check_eq("start_busy", o_busy, 1);
        check_eq("start_av", o_a_num_valid, 1);
        check_eq("start_bv", o_b_num_valid, 0);
        check_eq("start_done", o_done, 0);
        check_eq("start_err", o_err, 0);
        check_eq("start_state", o_dbg_state, SEND_A);
    endtask

    task automatic run_ops(input int pace, input bit poke, input int stop_at);
        int cyc; int xfers; bit held; bit poked; bit acc;
        logic [7:0] held_v; logic [7:0] cur;
        cyc = 0; xfers = 0; held = 0; poked = 0; held_v = '0;
        while (exp_q.size() > 0 && (stop_at == 0 || xfers < stop_at) && cyc < 500) begin
            cyc++;
            i_a_read = (cyc % pace == 0);
            i_b_read = (cyc % pace == 0);
            i_start = 1'b0; i_load_we = 1'b0;
            if (poke && !poked && o_b_num_valid) begin
                i_start = 1'b1; i_load_we = 1'b1; i_load_sel = 1'b0;
                i_load_addr = 4'd0; i_load_data = 8'h55;
                poked = 1;
            end
            check_eq("op_excl", o_a_num_valid & o_b_num_valid, 0);
            check_eq("op_rdy_lo", o_res_ready, 0);
            if (o_a_num_valid || o_b_num_valid) begin
                cur = o_a_num_valid ? o_a_num : o_b_num;
                acc = (o_a_num_valid && i_a_read) || (o_b_num_valid && i_b_read);
                if (held) check_eq("op_hold", cur, held_v);
                if (acc) begin
                    check_eq("op_is_a", o_a_num_valid, (xfers % 6) < 3);
                    check_eq("op_val", cur, exp_q.pop_front());
                    xfers++;
                    held = 0;
                end else begin
                    held = 1;
                    held_v = cur;
                end
            end
            @(negedge i_clk);
        end
        i_a_read = 1'b0; i_b_read = 1'b0; i_start = 1'b0; i_load_we = 1'b0;
        check_eq("op_count", xfers, (stop_at == 0) ? 18 : stop_at);
        if (stop_at == 0) begin
            check_eq("rdy_rise", o_res_ready, 1);
            check_eq("st_collect", o_dbg_state, COLLECT);
        end
    endtask

    task automatic run_results(input logic [7:0] base, input int last_idx);
        int idx; int cyc; bit tog;
        idx = 0; cyc = 0; tog = 0;
        while (idx < 9 && cyc < 200) begin
            cyc++;
            tog = ~tog;
            i_res_valid = tog;
            i_res_data  = base + 8'(idx);
            i_res_last  = tog && (idx == last_idx);
            if (tog && o_res_ready) idx++;
            @(negedge i_clk);
        end
        i_res_valid = 1'b0; i_res_last = 1'b0;
        check_eq("res_count", idx, 9);
        check_eq("res_busy", o_busy, 0);
        check_eq("res_done", o_done, 1);
        check_eq("res_rdy", o_res_ready, 0);
        check_eq("res_state", o_dbg_state, IDLE);
    endtask

    task automatic check_rd(input logic [7:0] base);
        for (int a = 0; a < 16; a++) begin
            i_rd_addr = 4'(a);
            #1;
            check_eq($sformatf("rd_%0d", a), o_rd_data, (a < 9) ? base + 8'(a) : 8'h00);
        end
        @(negedge i_clk);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_eq("rst_av", o_a_num_valid, 0);
        check_eq("rst_bv", o_b_num_valid, 0);
        check_eq("rst_rdy", o_res_ready, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_state", o_dbg_state, IDLE);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 9; i++) load_elem(1'b0, 4'(i), (i % 4 == 0) ? Q44_ONE : 8'h00);
        for (int i = 0; i < 9; i++) load_elem(1'b1, 4'(i), 8'(i + 1));
        load_elem(1'b0, 4'd12, 8'h77);

        // Full-rate operand order and collect.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 0, 0);
        run_results(8'hF0, 8);
        repeat (3) @(negedge i_clk);
        check_eq("t1_err", o_err, 0);
        check_rd(8'hF0);

        // Backpressure: reads high every third cycle.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(3, 0, 0);
        run_results(8'h30, 8);
        check_rd(8'h30);

        // Start and A write during SEND_B are ignored.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 1, 0);
        run_results(8'hF0, 8);

        // Mid-run reset at SEND_B k=1, then replay with a start-cycle write to B[0].
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 0, 9);
        check_eq("pre_rst_bv", o_b_num_valid, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("mrst_av", o_a_num_valid, 0);
        check_eq("mrst_bv", o_b_num_valid, 0);
        check_eq("mrst_busy", o_busy, 0);
        check_eq("mrst_done", o_done, 0);
        check_eq("mrst_state", o_dbg_state, IDLE);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        do_start(1'b1, 1'b1, 4'd0, 8'hAA);
        run_ops(2, 0, 0);
        run_results(8'h40, 8);
        check_rd(8'h40);

        // Early i_res_last on result 5.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 0, 0);
        run_results(8'h60, 4);
        check_eq("early_err", o_err, ERR_EN);
        repeat (4) @(negedge i_clk);
        check_eq("early_err_hold", o_err, ERR_EN);

        // Missing i_res_last on the final word.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 0, 0);
        run_results(8'h70, -1);
        check_eq("miss_err_wait", o_err, 0);
        repeat (3) @(negedge i_clk);
        check_eq("miss_err", o_err, ERR_EN);

        // i_res_last arriving one cycle after the final word is tolerated.
        do_start(1'b0, 1'b0, 4'd0, 8'h00);
        run_ops(1, 0, 0);
        run_results(8'h80, -1);
        i_res_last = 1'b1;
        @(negedge i_clk);
        i_res_last = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("late_err", o_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
